std_seq_divmod: RTL and testbench



---
 rtl/std_divmod_pkg.sv | 22 ++
 rtl/std_divmod_step.sv | 22 ++
 rtl/std_seq_divmod.sv | 129 ++++++++++++
 tb/tb_std_seq_divmod.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/std_divmod_pkg.sv
// Shared types and two's-complement helpers for the sequential divider.
// Helpers work on MAX_W bits; callers truncate, so operand widths up to MAX_W are supported.
package std_divmod_pkg;

  localparam int MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    DONE
  } state_e;

  function automatic logic [MAX_W-1:0] twos_neg(input logic [MAX_W-1:0] v);
    return ~v + MAX_W'(1);
  endfunction

  function automatic logic [MAX_W-1:0] mag(input logic [MAX_W-1:0] v, input logic neg);
    return neg ? twos_neg(v) : v;
  endfunction

endpackage

// File: rtl/std_divmod_step.sv
// One restoring shift-subtract iteration on unsigned magnitudes.
module std_divmod_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] dvs_i,
  input  logic             bit_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             qbit_o
);

  logic [WIDTH-1:0] low;

  // A set MSB shifted out means the true value is >= 2^WIDTH > divisor, and the
  // difference still fits in WIDTH bits, so modular subtraction is exact.
  always_comb begin
    low    = {rem_i[WIDTH-2:0], bit_i};
    qbit_o = rem_i[WIDTH-1] | (low >= dvs_i);
    rem_o  = qbit_o ? (low - dvs_i) : low;
  end

endmodule

// File: rtl/std_seq_divmod.sv
// Multi-cycle quotient/remainder divider with go/done handshake; truncating signed mode.
// IDLE: wait for go | RUN: WIDTH restoring steps | FIX: signs, specials, outputs | DONE: done pulse
module std_seq_divmod
  import std_divmod_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter bit SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [WIDTH-1:0] left,
  input  logic [WIDTH-1:0] right,
  output logic [WIDTH-1:0] out_quotient,
  output logic [WIDTH-1:0] out_remainder,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] left_q, left_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] outq_q, outq_d;
  logic [WIDTH-1:0] outr_q, outr_d;

  logic             sl, sr;
  logic [WIDTH-1:0] step_rem;
  logic             step_qbit;

  // quo_q starts as the dividend magnitude and shifts quotient bits in from the right.
  std_divmod_step #(.WIDTH(WIDTH)) u_step (
    .rem_i  (rem_q),
    .dvs_i  (dvs_q),
    .bit_i  (quo_q[WIDTH-1]),
    .rem_o  (step_rem),
    .qbit_o (step_qbit)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    left_d  = left_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    dz_d    = dz_q;
    outq_d  = outq_q;
    outr_d  = outr_q;
    sl      = SIGNED ? left[WIDTH-1]  : 1'b0;
    sr      = SIGNED ? right[WIDTH-1] : 1'b0;

    case (state_q)
      IDLE: begin
        if (go) begin
          left_d  = left;
          rem_d   = '0;
          quo_d   = WIDTH'(mag(MAX_W'(left), sl));
          dvs_d   = WIDTH'(mag(MAX_W'(right), sr));
          negq_d  = sl ^ sr;
          negr_d  = sl;
          dz_d    = (right == '0);
          cnt_d   = CW'(WIDTH);
          state_d = RUN;
        end
      end
      RUN: begin
        rem_d = step_rem;
        quo_d = {quo_q[WIDTH-2:0], step_qbit};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = FIX;
      end
      FIX: begin
        // Most-negative / -1 needs no special path: 2^(WIDTH-1) unnegated is already the wrapped result.
        if (dz_q) begin
          outq_d = '1;
          outr_d = left_q;
        end else begin
          outq_d = negq_q ? WIDTH'(twos_neg(MAX_W'(quo_q))) : quo_q;
          outr_d = negr_q ? WIDTH'(twos_neg(MAX_W'(rem_q))) : rem_q;
        end
        state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      left_q  <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      dz_q    <= 1'b0;
      outq_q  <= '0;
      outr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      left_q  <= left_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      dz_q    <= dz_d;
      outq_q  <= outq_d;
      outr_q  <= outr_d;
    end
  end

  assign out_quotient  = outq_q;
  assign out_remainder = outr_q;
  assign done          = (state_q == DONE);

endmodule

// File: tb/tb_std_seq_divmod.sv
// Bench for std_seq_divmod: four instances (32/8 bit, unsigned/signed) against an arithmetic model.
module tb_std_seq_divmod;

  logic        clk;
  logic        reset;
  logic        go;
  logic [31:0] l32, r32;
  logic [7:0]  l8, r8;

  logic [31:0] q_u32, rm_u32, q_s32, rm_s32;
  logic [7:0]  q_u8, rm_u8, q_s8, rm_s8;
  logic        d_u32, d_s32, d_u8, d_s8;

  logic [31:0] oq [4];
  logic [31:0] orr [4];
  logic        dn [4];

  int total = 0;
  int bad   = 0;

  int          b2b_c[$];
  logic [31:0] b2b_q[$];
  logic [31:0] b2b_r[$];
  int          ndone;

  std_seq_divmod #(.WIDTH(32), .SIGNED(1'b0)) u_u32 (
    .clk(clk), .reset(reset), .go(go), .left(l32), .right(r32),
    .out_quotient(q_u32), .out_remainder(rm_u32), .done(d_u32));
  std_seq_divmod #(.WIDTH(32), .SIGNED(1'b1)) u_s32 (
    .clk(clk), .reset(reset), .go(go), .left(l32), .right(r32),
    .out_quotient(q_s32), .out_remainder(rm_s32), .done(d_s32));
  std_seq_divmod #(.WIDTH(8), .SIGNED(1'b0)) u_u8 (
    .clk(clk), .reset(reset), .go(go), .left(l8), .right(r8),
    .out_quotient(q_u8), .out_remainder(rm_u8), .done(d_u8));
  std_seq_divmod #(.WIDTH(8), .SIGNED(1'b1)) u_s8 (
    .clk(clk), .reset(reset), .go(go), .left(l8), .right(r8),
    .out_quotient(q_s8), .out_remainder(rm_s8), .done(d_s8));

  assign oq[0]  = q_u32;
  assign oq[1]  = q_s32;
  assign oq[2]  = {24'h0, q_u8};
  assign oq[3]  = {24'h0, q_s8};
  assign orr[0] = rm_u32;
  assign orr[1] = rm_s32;
  assign orr[2] = {24'h0, rm_u8};
  assign orr[3] = {24'h0, rm_s8};
  assign dn[0]  = d_u32;
  assign dn[1]  = d_s32;
  assign dn[2]  = d_u8;
  assign dn[3]  = d_s8;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int w_of(input int i);
    return (i < 2) ? 32 : 8;
  endfunction

  // Reference: plain integer / and % on 64-bit values, then wrap to the instance width.
  function automatic void ref_div(input int w, input bit sgn, input logic [31:0] a,
                                  input logic [31:0] b, output logic [31:0] q,
                                  output logic [31:0] r);
    logic [31:0] mask;
    longint      sa, sb, qq, rr;
    mask = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_00FF;
    if (sgn) begin
      sa = (w == 32) ? longint'($signed(a)) : longint'($signed(a[7:0]));
      sb = (w == 32) ? longint'($signed(b)) : longint'($signed(b[7:0]));
    end else begin
      sa = longint'(a & mask);
      sb = longint'(b & mask);
    end
    if (sb == 0) begin
      q = mask;
      r = a & mask;
    end else begin
      qq = sa / sb;
      rr = sa % sb;
      q  = 32'(qq) & mask;
      r  = 32'(rr) & mask;
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Launches one operation on all four instances, scrambles the operands after acceptance,
  // and checks pulse count, latency, results and that results hold afterwards.
  task automatic run_op(input logic [31:0] a32, input logic [31:0] b32,
                        input logic [7:0] a8, input logic [7:0] b8);
    int          cyc_at [4];
    int          cnt [4];
    logic [31:0] cq [4];
    logic [31:0] cr [4];
    logic [31:0] eq, er;
    for (int i = 0; i < 4; i++) begin
      cyc_at[i] = -1;
      cnt[i]    = 0;
      cq[i]     = '0;
      cr[i]     = '0;
    end
    l32 = a32; r32 = b32; l8 = a8; r8 = b8; go = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (c == 1) begin
        go  = 1'b0;
        l32 = $urandom;
        r32 = $urandom;
        l8  = 8'($urandom);
        r8  = 8'($urandom);
      end
      for (int i = 0; i < 4; i++) begin
        if (dn[i]) begin
          cnt[i]++;
          if (cyc_at[i] < 0) begin
            cyc_at[i] = c;
            cq[i]     = oq[i];
            cr[i]     = orr[i];
          end
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      ref_div(w_of(i), i[0], (i < 2) ? a32 : {24'h0, a8}, (i < 2) ? b32 : {24'h0, b8}, eq, er);
      chk($sformatf("pulses[%0d] %h/%h", i, a32, a8), 32'(cnt[i]), 32'd1);
      chk($sformatf("latency[%0d]", i), 32'(cyc_at[i]), 32'(w_of(i) + 2));
      chk($sformatf("quot[%0d] %h/%h %h/%h", i, a32, b32, a8, b8), cq[i], eq);
      chk($sformatf("rem[%0d] %h/%h %h/%h", i, a32, b32, a8, b8), cr[i], er);
      chk($sformatf("hold_quot[%0d]", i), oq[i], eq);
    end
  endtask

  initial begin
    logic [31:0] a32, b32;
    logic [7:0]  a8, b8;
    int          sel;

    reset = 1'b1; go = 1'b0; l32 = '0; r32 = '0; l8 = '0; r8 = '0;
    @(negedge clk);
    tick(); tick();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst_quot[%0d]", i), oq[i], 32'h0);
      chk($sformatf("rst_rem[%0d]", i), orr[i], 32'h0);
      chk($sformatf("rst_done[%0d]", i), {31'h0, dn[i]}, 32'h0);
    end
    reset = 1'b0;
    tick();

    // Directed: 100/7, -7/2, 7/-2, min/-1, divide by zero
    run_op(32'd100, 32'd7, 8'hF9, 8'd2);
    run_op(32'd7, 32'hFFFF_FFFE, 8'd7, 8'hFE);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 8'h80, 8'hFF);
    run_op(32'h0000_005A, 32'h0, 8'h5A, 8'h00);
    run_op(32'hFFFF_FF00, 32'h0, 8'hA5, 8'h00);
    run_op(32'hFFFF_FFFF, 32'd1, 8'hFF, 8'h01);

    // Back-to-back with go held; the 8-bit unsigned lane supplies the second operation's operands
    l32 = 32'd5000; r32 = 32'd9; l8 = 8'd200; r8 = 8'd7; go = 1'b1;
    b2b_c.delete(); b2b_q.delete(); b2b_r.delete();
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (c == 1) begin l8 = 8'd99; r8 = 8'd10; end
      if (c == 12) go = 1'b0;
      if (dn[2]) begin
        b2b_c.push_back(c);
        b2b_q.push_back(oq[2]);
        b2b_r.push_back(orr[2]);
      end
    end
    chk("b2b_count", 32'(b2b_c.size()), 32'd2);
    if (b2b_c.size() == 2) begin
      chk("b2b_first_at", 32'(b2b_c[0]), 32'd10);
      chk("b2b_spacing", 32'(b2b_c[1] - b2b_c[0]), 32'd11);
      chk("b2b_q0", b2b_q[0], 32'd28);
      chk("b2b_r0", b2b_r[0], 32'd4);
      chk("b2b_q1", b2b_q[1], 32'd9);
      chk("b2b_r1", b2b_r[1], 32'd9);
    end
    repeat (40) tick();

    // Reset during RUN step 5
    run_op(32'd1000, 32'd3, 8'd77, 8'd5);
    l32 = 32'd123456; r32 = 32'd11; l8 = 8'd90; r8 = 8'd4; go = 1'b1;
    ndone = 0;
    for (int c = 1; c <= 45; c++) begin
      tick();
      if (c == 1) go = 1'b0;
      if (c == 4) reset = 1'b1;
      if (c == 5) begin
        for (int i = 0; i < 4; i++) begin
          chk($sformatf("abort_quot[%0d]", i), oq[i], 32'h0);
          chk($sformatf("abort_rem[%0d]", i), orr[i], 32'h0);
        end
        reset = 1'b0;
      end
      for (int i = 0; i < 4; i++) if (dn[i]) ndone++;
    end
    chk("abort_no_done", 32'(ndone), 32'd0);
    run_op(32'd123456, 32'd11, 8'd90, 8'd4);

    // Reset and go in the same cycle: go is not accepted
    reset = 1'b1; go = 1'b1; l32 = 32'd50; r32 = 32'd3; l8 = 8'd50; r8 = 8'd3;
    tick();
    reset = 1'b0; go = 1'b0;
    ndone = 0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      for (int i = 0; i < 4; i++) if (dn[i]) ndone++;
    end
    chk("rstgo_no_done", 32'(ndone), 32'd0);
    chk("rstgo_quot", oq[0], 32'h0);

    // Random sweep with biased special cases
    for (int k = 0; k < 150; k++) begin
      a32 = $urandom;
      b32 = $urandom;
      a8  = 8'($urandom);
      b8  = 8'($urandom);
      sel = $urandom_range(0, 7);
      case (sel)
        0: begin b32 = 32'h0; b8 = 8'h0; end
        1: begin b32 = 32'hFFFF_FFFF; b8 = 8'hFF; end
        2: begin a32 = 32'h8000_0000; a8 = 8'h80; end
        3: begin b32 = $urandom_range(1, 300); b8 = 8'($urandom_range(1, 15)); end
        default: ;
      endcase
      run_op(a32, b32, a8, b8);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
